// File: rtl/regs_write_arbiter_if.sv
// rtl/regs_write_arbiter_if.sv - write requester handshake bundle
//
// Purpose: one requester's write channel into regs_write_arbiter.
// Signals:
//   valid  requester has a write pending
//   dst    destination register index (DST_W bits)
//   data   32-bit write data
//   ready  arbiter accepts the transfer when valid && ready at a rising edge
// Modports: master (requester side), slave (arbiter side).
interface regs_write_arbiter_if #(
  parameter int DST_W = 5
);
  logic             valid;
  logic [DST_W-1:0] dst;
  logic [31:0]      data;
  logic             ready;

  modport master (output valid, dst, data, input ready);
  modport slave  (input valid, dst, data, output ready);
endinterface

// File: rtl/regs_write_arbiter.sv
// rtl/regs_write_arbiter.sv - two-requester register file write arbiter
//
// Purpose: merges execute (req0) and load (req1) writebacks onto one
// register file write port. Each requester owns a one-entry holding buffer;
// one buffer is granted per cycle and copied to registered outputs.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req0, req1      requester channels (regs_write_arbiter_if.slave)
//   regs_wr_dst     registered destination index
//   regs_wr_data    registered write data
//   regs_wr_sync    one-cycle write strobe (suppressed for dst == 0)
//   collision_cnt   saturating count of cycles with both buffers full
// Configuration: define REGS_WRITE_ARBITER_RR_EN for round-robin between
// two full buffers with different dst; default is fixed priority to req0.
module regs_write_arbiter #(
  parameter int DST_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regs_write_arbiter_if.slave  req0,
  regs_write_arbiter_if.slave  req1,
  output logic [DST_W-1:0]     regs_wr_dst,
  output logic [31:0]          regs_wr_data,
  output logic                 regs_wr_sync,
  output logic [15:0]          collision_cnt
);

  logic             full0, full1;
  logic             age0, age1;
  logic [DST_W-1:0] dst0, dst1;
  logic [31:0]      data0, data1;

  logic             both_full, same_dst;
  logic             gnt0, gnt1;
  logic             acc0, acc1;
  logic [DST_W-1:0] gnt_dst;
  logic [31:0]      gnt_data;

`ifdef REGS_WRITE_ARBITER_RR_EN
  logic             rr_ptr;
  logic             contested;
  assign contested = both_full && !same_dst;
`endif

  always_comb begin
    both_full = full0 && full1;
    same_dst  = (dst0 == dst1);
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (both_full) begin
      if (same_dst) begin
        // Same register: older entry first; equal age means same-edge
        // acceptance, where buffer 0 goes first.
        gnt1 = age1 && !age0;
      end else begin
`ifdef REGS_WRITE_ARBITER_RR_EN
        gnt1 = rr_ptr;
`else
        gnt1 = 1'b0;
`endif
      end
      gnt0 = !gnt1;
    end else begin
      gnt0 = full0;
      gnt1 = full1;
    end
    gnt_dst  = gnt1 ? dst1 : dst0;
    gnt_data = gnt1 ? data1 : data0;
  end

  // A buffer being drained this cycle can take a new entry at the same edge.
  assign req0.ready = !full0 || gnt0;
  assign req1.ready = !full1 || gnt1;
  assign acc0       = req0.valid && req0.ready;
  assign acc1       = req1.valid && req1.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      full0         <= 1'b0;
      full1         <= 1'b0;
      age0          <= 1'b0;
      age1          <= 1'b0;
      regs_wr_dst   <= '0;
      regs_wr_data  <= '0;
      regs_wr_sync  <= 1'b0;
      collision_cnt <= '0;
`ifdef REGS_WRITE_ARBITER_RR_EN
      rr_ptr        <= 1'b0;
`endif
    end else begin
      if (acc0) begin
        full0 <= 1'b1;
        dst0  <= req0.dst;
        data0 <= req0.data;
      end else if (gnt0) begin
        full0 <= 1'b0;
      end

      if (acc1) begin
        full1 <= 1'b1;
        dst1  <= req1.dst;
        data1 <= req1.data;
      end else if (gnt1) begin
        full1 <= 1'b0;
      end

      // Age bit set means this buffer's entry predates the other's: a fresh
      // load is young, and a buffer becomes old when the other one reloads.
      age0 <= acc0 ? 1'b0 : (age0 | acc1);
      age1 <= acc1 ? 1'b0 : (age1 | acc0);

      if (gnt0 || gnt1) begin
        regs_wr_dst  <= gnt_dst;
        regs_wr_data <= gnt_data;
        regs_wr_sync <= (gnt_dst != '0);
      end else begin
        regs_wr_sync <= 1'b0;
      end

      if (both_full && (collision_cnt != 16'hFFFF)) begin
        collision_cnt <= collision_cnt + 16'd1;
      end

`ifdef REGS_WRITE_ARBITER_RR_EN
      if (contested) begin
        rr_ptr <= !rr_ptr;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regs_write_arbiter.sv
// tb/tb_regs_write_arbiter.sv - directed bench for regs_write_arbiter
module tb_regs_write_arbiter;

  logic        clk;
  logic        rst;
  logic [4:0]  regs_wr_dst;
  logic [31:0] regs_wr_data;
  logic        regs_wr_sync;
  logic [15:0] collision_cnt;

  int tests_run;
  int tests_failed;
  logic [31:0] x7_value;

  regs_write_arbiter_if #(.DST_W(5)) req0_if ();
  regs_write_arbiter_if #(.DST_W(5)) req1_if ();

  regs_write_arbiter #(.DST_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0          (req0_if),
    .req1          (req1_if),
    .regs_wr_dst   (regs_wr_dst),
    .regs_wr_data  (regs_wr_data),
    .regs_wr_sync  (regs_wr_sync),
    .collision_cnt (collision_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_if.valid = 1'b0;
    req1_if.valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    x7_value      = 32'h0;
    rst           = 1'b1;
    req0_if.valid = 1'b0;
    req0_if.dst   = 5'd0;
    req0_if.data  = 32'h0;
    req1_if.valid = 1'b0;
    req1_if.dst   = 5'd0;
    req1_if.data  = 32'h0;
    step();
    step();
    rst = 1'b0;

    check("rst_sync",   regs_wr_sync,  1'b0);
    check("rst_dst",    regs_wr_dst,   5'd0);
    check("rst_data",   regs_wr_data,  32'h0);
    check("rst_cnt",    collision_cnt, 16'h0);
    check("rst_ready0", req0_if.ready, 1'b1);
    check("rst_ready1", req1_if.ready, 1'b1);

    // Single write from requester 0
    req0_if.valid = 1'b1;
    req0_if.dst   = 5'd5;
    req0_if.data  = 32'hDEADBEEF;
    step();
    req0_if.valid = 1'b0;
    check("single_sync_e",   regs_wr_sync,  1'b0);
    check("single_ready0_e", req0_if.ready, 1'b1);
    step();
    check("single_sync",   regs_wr_sync,  1'b1);
    check("single_dst",    regs_wr_dst,   5'd5);
    check("single_data",   regs_wr_data,  32'hDEADBEEF);
    check("single_ready0", req0_if.ready, 1'b1);
    step();
    check("single_sync_off", regs_wr_sync, 1'b0);
    check("single_dst_hold", regs_wr_dst,  5'd5);

    // Write to x0 is consumed without a strobe
    req1_if.valid = 1'b1;
    req1_if.dst   = 5'd0;
    req1_if.data  = 32'h12345678;
    step();
    req1_if.valid = 1'b0;
    step();
    check("x0_sync", regs_wr_sync, 1'b0);
    step();
    check("x0_sync2",  regs_wr_sync,  1'b0);
    check("x0_ready1", req1_if.ready, 1'b1);

    // Same-register ordering: req1 x7=1 is older than req0 x7=2
    req0_if.valid = 1'b1;
    req0_if.dst   = 5'd9;
    req0_if.data  = 32'hAA;
    req1_if.valid = 1'b1;
    req1_if.dst   = 5'd7;
    req1_if.data  = 32'h1;
    step();
    req1_if.valid = 1'b0;
    req0_if.dst   = 5'd7;
    req0_if.data  = 32'h2;
    check("ord_ready0", req0_if.ready, 1'b1);
    check("ord_ready1", req1_if.ready, 1'b0);
    step();
    req0_if.valid = 1'b0;
    check("ord_w1_sync", regs_wr_sync, 1'b1);
    check("ord_w1_dst",  regs_wr_dst,  5'd9);
    check("ord_w1_data", regs_wr_data, 32'hAA);
    step();
    check("ord_w2_sync", regs_wr_sync, 1'b1);
    check("ord_w2_dst",  regs_wr_dst,  5'd7);
    check("ord_w2_data", regs_wr_data, 32'h1);
    if (regs_wr_sync && regs_wr_dst == 5'd7) x7_value = regs_wr_data;
    step();
    check("ord_w3_sync", regs_wr_sync, 1'b1);
    check("ord_w3_dst",  regs_wr_dst,  5'd7);
    check("ord_w3_data", regs_wr_data, 32'h2);
    if (regs_wr_sync && regs_wr_dst == 5'd7) x7_value = regs_wr_data;
    check("ord_x7_final", x7_value, 32'h2);
    check("ord_cnt", collision_cnt, 16'd2);
    step();
    check("ord_idle", regs_wr_sync, 1'b0);

    // Continuous contention, dst 3 versus dst 4
    do_reset();
    req0_if.valid = 1'b1;
    req0_if.dst   = 5'd3;
    req0_if.data  = 32'h30000003;
    req1_if.valid = 1'b1;
    req1_if.dst   = 5'd4;
    req1_if.data  = 32'h40000004;
    step();
    check("cont_cnt0", collision_cnt, 16'd0);
    for (int i = 0; i < 6; i++) begin
      logic [4:0]  exp_dst;
      logic [31:0] exp_data;
`ifdef REGS_WRITE_ARBITER_RR_EN
      exp_dst = (i % 2 == 0) ? 5'd3 : 5'd4;
`else
      exp_dst = 5'd3;
`endif
      exp_data = (exp_dst == 5'd3) ? 32'h30000003 : 32'h40000004;
      step();
      check("cont_sync", regs_wr_sync, 1'b1);
      check("cont_dst",  regs_wr_dst,  exp_dst);
      check("cont_data", regs_wr_data, exp_data);
      check("cont_cnt",  collision_cnt, 16'(i + 1));
    end

    // Reset while both buffers are full
    rst = 1'b1;
    req0_if.valid = 1'b0;
    req1_if.valid = 1'b0;
    step();
    rst = 1'b0;
    check("mid_rst_sync",   regs_wr_sync,  1'b0);
    check("mid_rst_cnt",    collision_cnt, 16'd0);
    check("mid_rst_ready0", req0_if.ready, 1'b1);
    check("mid_rst_ready1", req1_if.ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_rst_nostrobe", regs_wr_sync, 1'b0);
    end

    // Saturation of the collision counter
    req0_if.valid = 1'b1;
    req1_if.valid = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    check("sat_cnt", collision_cnt, 16'hFFFF);
    for (int i = 0; i < 3; i++) step();
    check("sat_hold", collision_cnt, 16'hFFFF);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regs_write_arbiter.md
REGS_WRITE_ARBITER -- requirements
Module: regs_write_arbiter

Interface
REQ-001 The block SHALL have one parameter: DST_W, default 5, register index width.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req0_valid  in  1  requester 0 (execute writeback) has a write pending.
REQ-005 req0_dst  in  DST_W  destination register index for requester 0.
REQ-006 req0_data  in  32  write data for requester 0.
REQ-007 req0_ready  out  1  requester 0 transfer accepted when req0_valid && req0_ready at a rising edge.
REQ-008 req1_valid / req1_dst / req1_data / req1_ready  in/in/in/out  1/DST_W/32/1  requester 1 (load writeback), with the same semantics as requester 0.
REQ-009 regs_wr_dst  out  DST_W  registered destination index to the register file write port.
REQ-010 regs_wr_data  out  32  registered write data to the register file write port.
REQ-011 regs_wr_sync  out  1  one-cycle write strobe; the register file writes when high.
REQ-012 collision_cnt  out  16  count of cycles in which both holding buffers are full.

Function
REQ-013 Each requester SHALL own a one-entry holding buffer (full flag, dst, data, age bit).
REQ-014 reqN_ready SHALL be 1 when buffer N is empty or buffer N is granted in the current cycle (same-cycle refill).
REQ-015 An accepted transfer SHALL load buffer N at the accepting edge.
REQ-016 Each cycle, at most one full buffer SHALL be granted.
- The granted entry is copied to the output registers at the next edge.
- Buffer N clears at that edge unless it is refilled at the same edge.
REQ-017 Latency SHALL be fixed: accepted at edge E, the grant is made in the cycle after E, and regs_wr_sync is high for exactly one cycle starting at edge E+1.
REQ-018 regs_wr_sync SHALL be 0 in every cycle with no grant in the previous cycle; regs_wr_dst and regs_wr_data SHALL hold their last value.
REQ-019 A granted entry with dst == 0 SHALL be consumed normally but SHALL NOT assert regs_wr_sync.
REQ-020 Write ordering for the same register:
- When both buffers are full with equal dst, the older entry (accepted at an earlier edge) SHALL be granted first, regardless of policy.
- When both were accepted at the same edge, buffer 0 SHALL be granted first.
REQ-021 When both buffers are full with different dst, the arbitration policy (REQ-027/028) SHALL decide.
REQ-022 When exactly one buffer is full, it SHALL be granted.
REQ-023 collision_cnt SHALL increment by 1 in every cycle in which both buffers are full.
- It saturates at 16'hFFFF; no wrap-around.
REQ-024 With both requesters streaming valid continuously, sustained throughput SHALL be one write per cycle, and neither requester SHALL wait more than 1 cycle between grants while in round-robin mode.

Reset
REQ-025 While rst is high at a rising edge, the block SHALL clear:
- both buffers' full flags;
- regs_wr_sync, regs_wr_dst, regs_wr_data and collision_cnt (all to 0);
- the round-robin pointer (to 0, meaning requester 0 has priority next).
reqN_ready SHALL be 1 in the first cycle after reset.
REQ-026 Reset asserted mid-operation SHALL discard buffered entries without issuing any write strobe.

Configuration
REQ-027 With macro REGS_WRITE_ARBITER_RR_EN defined, arbitration between two full buffers with different dst SHALL be round-robin.
- A one-bit pointer names the favoured requester.
- After each contested grant, the pointer moves to the other requester.
- Uncontested grants leave the pointer unchanged.
REQ-028 Without REGS_WRITE_ARBITER_RR_EN, arbitration SHALL be fixed priority with requester 0 winning, and the pointer SHALL NOT be implemented.

Verification
REQ-029 Single write: req0 dst=5 data=32'hDEADBEEF accepted at edge E -> regs_wr_sync=1 for one cycle after E+1 with dst=5, data=32'hDEADBEEF; req0_ready stays 1.
REQ-030 x0 drop: req1 dst=0 data=32'h12345678 -> entry consumed, regs_wr_sync stays 0, req1_ready returns to 1.
REQ-031 Same-register ordering: req1 dst=7 data=1 accepted at E, buffer 0 held full; req0 dst=7 data=2 accepted at E+1 while buffer 1 is blocked -> writes issue data=1 then data=2; final x7 value is 2.
REQ-032 Contention with RR enabled: both valid continuously, dst0=3, dst1=4, for 6 cycles -> strobes alternate 3,4,3,4,…; collision_cnt increments by 1 per cycle in which both buffers are full. Without the macro -> req0 wins every contested cycle.
REQ-033 Reset mid-operation: both buffers full, rst high for one edge -> no strobe afterwards, collision_cnt=0, both ready=1.
REQ-034 Saturation: force 70000 contested cycles -> collision_cnt=16'hFFFF and holds.
